// File: rtl/queen_job_ctrl.sv
// queen_job_ctrl: buffers one placement job, replays it to the QUEEN core, then collects and drains the answer.
module queen_job_ctrl #(
    parameter int BOARD   = 12,
    parameter int MAX_NUM = 7,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_valid,
    output logic       h_ready,
    input  logic [3:0] h_col,
    input  logic [3:0] h_row,
    input  logic       h_last,
    output logic       q_in_valid,
    output logic       q_in_valid_num,
    output logic [2:0] q_in_num,
    output logic [3:0] q_col,
    output logic [3:0] q_row,
    input  logic       q_out_valid,
    input  logic [3:0] q_out,
    output logic       r_valid,
    input  logic       r_ready,
    output logic [3:0] r_data,
    output logic       r_last,
    output logic       busy,
    output logic       err
);
    typedef enum logic [2:0] {LOAD, ISSUE, WAIT, COLLECT, DRAIN} state_t;

    localparam logic [2:0] CNT_LAST = 3'(MAX_NUM - 1);
    localparam logic [3:0] BOARD_N  = 4'(BOARD);
    localparam logic [9:0] WD_LAST  = 10'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] ptr_q, ptr_d;
    logic [3:0] idx_q, idx_d;
    logic [9:0] wd_q, wd_d;
    logic       err_q, err_d;
    logic       q_in_valid_q, q_in_valid_d;
    logic       q_in_valid_num_q, q_in_valid_num_d;
    logic [2:0] q_in_num_q, q_in_num_d;
    logic [3:0] q_col_q, q_col_d;
    logic [3:0] q_row_q, q_row_d;
    logic [7:0] pbuf_q [MAX_NUM];
    logic [3:0] res_q [BOARD];

    assign h_ready        = state_q == LOAD;
    assign busy           = state_q != LOAD;
    assign err            = err_q;
    assign r_valid        = state_q == DRAIN;
    // idx holds the captured length while draining
    assign r_last         = r_valid && ptr_q == idx_q - 4'd1;
    assign r_data         = r_valid ? res_q[ptr_q] : '0;
    assign q_in_valid     = q_in_valid_q;
    assign q_in_valid_num = q_in_valid_num_q;
    assign q_in_num       = q_in_num_q;
    assign q_col          = q_col_q;
    assign q_row          = q_row_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            LOAD: if (h_valid) begin
                cnt_d   = cnt_q + 3'd1;
                err_d   = (cnt_q == 3'd0) ? 1'b0 : err_q;
                state_d = (h_last || cnt_q == CNT_LAST) ? ISSUE : LOAD;
            end
            ISSUE: begin
                ptr_d = ptr_q + 4'd1;
                if (ptr_q[2:0] == cnt_q - 3'd1) begin
                    ptr_d   = '0;
                    wd_d    = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wd_d = wd_q + 10'd1;
                if (q_out_valid) begin
                    idx_d   = 4'd1;
                    state_d = COLLECT;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            COLLECT: begin
                if (idx_q == BOARD_N) begin
                    state_d = DRAIN;
                end else if (q_out_valid) begin
                    idx_d = idx_q + 4'd1;
                end else begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (r_ready) begin
                ptr_d = ptr_q + 4'd1;
                if (r_last) begin
                    ptr_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        q_in_valid_d           = state_q == ISSUE;
        q_in_valid_num_d       = q_in_valid_d && ptr_q == 4'd0;
        q_in_num_d             = q_in_valid_num_d ? cnt_q : '0;
        {q_col_d, q_row_d}     = q_in_valid_d ? pbuf_q[ptr_q[2:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= LOAD;
            cnt_q            <= '0;
            ptr_q            <= '0;
            idx_q            <= '0;
            wd_q             <= '0;
            err_q            <= 1'b0;
            q_in_valid_q     <= 1'b0;
            q_in_valid_num_q <= 1'b0;
            q_in_num_q       <= '0;
            q_col_q          <= '0;
            q_row_q          <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ptr_q            <= ptr_d;
            idx_q            <= idx_d;
            wd_q             <= wd_d;
            err_q            <= err_d;
            q_in_valid_q     <= q_in_valid_d;
            q_in_valid_num_q <= q_in_valid_num_d;
            q_in_num_q       <= q_in_num_d;
            q_col_q          <= q_col_d;
            q_row_q          <= q_row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD && h_valid) pbuf_q[cnt_q] <= {h_col, h_row};
        if ((state_q == WAIT || (state_q == COLLECT && idx_q != BOARD_N)) && q_out_valid) res_q[idx_q] <= q_out;
    end
endmodule

// File: tb/tb_queen_job_ctrl.sv
// tb_queen_job_ctrl: drives host and core sides of queen_job_ctrl and checks every cycle against a job-level model.
module tb_queen_job_ctrl;
    localparam int TO = 1023;

    logic       clk = 0;
    logic       rst_n;
    logic       h_valid = 0, h_last = 0, q_out_valid = 0, r_ready = 0;
    logic [3:0] h_col = 0, h_row = 0, q_out = 0;
    logic       h_ready, q_in_valid, q_in_valid_num, r_valid, r_last, busy, err;
    logic [2:0] q_in_num;
    logic [3:0] q_col, q_row, r_data;

    queen_job_ctrl dut (
        .clk(clk), .rst_n(rst_n), .h_valid(h_valid), .h_ready(h_ready), .h_col(h_col), .h_row(h_row),
        .h_last(h_last), .q_in_valid(q_in_valid), .q_in_valid_num(q_in_valid_num), .q_in_num(q_in_num),
        .q_col(q_col), .q_row(q_row), .q_out_valid(q_out_valid), .q_out(q_out), .r_valid(r_valid),
        .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_vec = 0, n_mis = 0;
    int iss_t0 = -1000, iss_n = 0;
    int err_set_at = -1, err_clr_at = -1, busy_set_at = -1, busy_clr_at = -1, dr_t0 = -1;
    int rp = 0, exp_len = 0, cj = 0;
    int obs_iss = 0, obs_r = 0, obs_rv = 0, obs_num0 = 0, obs_col0 = 0, obs_row0 = 0, obs_last = -1;
    int rr_mode = 2, rr_ph = 0;
    bit exp_busy = 0, exp_err = 0, dr_on = 0, end_pending = 0, drain_done = 0, in_iss = 0;
    logic [3:0] plc_col [7];
    logic [3:0] plc_row [7];
    logic [3:0] exp_res [12];
    logic [3:0] dcol [7];
    logic [3:0] drow [7];

    task automatic chk(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_mis++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", nm, edge_n, act, want);
        end
    endtask

    // Expected outputs follow from job-level facts: when the job closed, which beats the core gave, and handshakes.
    always @(negedge clk) begin
        if (end_pending) begin
            end_pending = 0;
            dr_on = 0;
            exp_busy = 0;
            drain_done = 1;
        end
        if (edge_n == err_set_at) exp_err = 1;
        if (edge_n == err_clr_at) exp_err = 0;
        if (edge_n == busy_set_at) exp_busy = 1;
        if (edge_n == busy_clr_at) exp_busy = 0;
        if (edge_n == dr_t0) begin
            dr_on = 1;
            rp = 0;
        end
        in_iss = edge_n >= iss_t0 && edge_n < iss_t0 + iss_n;
        cj = in_iss ? edge_n - iss_t0 : 0;
        chk("q_in_valid", int'(q_in_valid), int'(in_iss));
        chk("q_in_valid_num", int'(q_in_valid_num), int'(in_iss && cj == 0));
        chk("q_in_num", int'(q_in_num), (in_iss && cj == 0) ? iss_n : 0);
        chk("q_col", int'(q_col), in_iss ? int'(plc_col[cj]) : 0);
        chk("q_row", int'(q_row), in_iss ? int'(plc_row[cj]) : 0);
        chk("h_ready", int'(h_ready), int'(!exp_busy));
        chk("busy", int'(busy), int'(exp_busy));
        chk("err", int'(err), int'(exp_err));
        chk("r_valid", int'(r_valid), int'(dr_on));
        chk("r_data", int'(r_data), dr_on ? int'(exp_res[rp]) : 0);
        chk("r_last", int'(r_last), int'(dr_on && rp == exp_len - 1));
        if (q_in_valid) begin
            obs_iss++;
            if (q_in_valid_num) begin
                obs_num0 = int'(q_in_num);
                obs_col0 = int'(q_col);
                obs_row0 = int'(q_row);
            end
        end
        if (r_valid) obs_rv++;
        if (dr_on && r_ready) begin
            obs_r++;
            if (rp == exp_len - 1) begin
                obs_last = int'(r_data);
                end_pending = 1;
            end else begin
                rp++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rr_ph = (rr_ph + 1) % 4;
            r_ready = rr_mode == 0 ? 1'($urandom_range(0, 1)) : rr_mode == 1 ? (rr_ph == 0 || rr_ph == 3) : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic junk();
        q_out_valid = 1'($urandom_range(0, 1));
        q_out = 4'($urandom_range(0, 15));
    endtask

    task automatic place_job(input int n, input bit use_last, input bit rnd);
        obs_iss = 0; obs_r = 0; obs_rv = 0; obs_num0 = 0; obs_col0 = 0; obs_row0 = 0; obs_last = -1;
        for (int i = 0; i < n; i++) begin
            h_valid = 0;
            repeat (rnd ? $urandom_range(0, 2) : 0) begin
                junk();
                step();
            end
            h_valid = 1;
            h_col = rnd ? 4'($urandom_range(0, 15)) : dcol[i];
            h_row = rnd ? 4'($urandom_range(0, 15)) : drow[i];
            h_last = use_last && i == n - 1;
            plc_col[i] = h_col;
            plc_row[i] = h_row;
            junk();
            step();
            if (i == 0) err_clr_at = edge_n;
        end
        iss_t0 = edge_n + 1;
        iss_n = n;
        busy_set_at = edge_n;
        chk("h_ready_drop", int'(h_ready), 0);
        h_col = 4'($urandom_range(0, 15));
        h_row = 4'($urandom_range(0, 15));
        h_last = 1'($urandom_range(0, 1));
        junk();
        step();
        h_valid = 0;
        h_last = 0;
    endtask

    task automatic respond(input int m, input int dly, input bit seq);
        int w, len;
        w = iss_t0 + iss_n - 1;
        drain_done = 0;
        while (edge_n < w) begin
            junk();
            step();
        end
        q_out_valid = 0;
        if (m == 0) begin
            err_set_at = w + TO;
            busy_clr_at = w + TO;
            while (edge_n < w + TO - 1) step();
            chk("timeout_early", int'(err), 0);
            step();
            chk("timeout_err", int'(err), 1);
            chk("timeout_h_ready", int'(h_ready), 1);
            chk("timeout_no_result", obs_rv, 0);
            return;
        end
        len = m < 12 ? m : 12;
        exp_len = len;
        repeat (dly) step();
        for (int b = 0; b < m; b++) begin
            q_out_valid = 1;
            q_out = seq ? 4'(b) : 4'($urandom_range(0, 15));
            if (b < len) exp_res[b] = q_out;
            step();
            if (b == len - 1) begin
                dr_t0 = edge_n + 1;
                if (m < 12) err_set_at = edge_n + 1;
            end
        end
        q_out_valid = 0;
        for (int t = 0; t < 4000 && !drain_done; t++) begin
            step();
            junk();
        end
        q_out_valid = 0;
        chk("drain_done", int'(drain_done), 1);
    endtask

    initial begin
        int n, m, sel;
        bit ul;
        rst_n = 1;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_h_ready", int'(h_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_r_valid", int'(r_valid), 0);
        chk("rst_q_in_valid", int'(q_in_valid), 0);
        rst_n = 1;
        step();

        rr_mode = 2;
        dcol[0] = 4'd3;
        drow[0] = 4'd5;
        place_job(1, 1, 0);
        respond(12, 2, 1);
        chk("single_num", obs_num0, 1);
        chk("single_col", obs_col0, 3);
        chk("single_row", obs_row0, 5);
        chk("single_beats", obs_iss, 1);
        chk("single_results", obs_r, 12);
        chk("single_last", obs_last, 11);
        chk("single_err", int'(err), 0);

        place_job(7, 0, 1);
        respond(13, 0, 0);
        chk("forced_num", obs_num0, 7);
        chk("forced_beats", obs_iss, 7);

        rr_mode = 1;
        place_job(3, 1, 1);
        respond(12, 1, 1);
        chk("bp_results", obs_r, 12);
        chk("bp_last", obs_last, 11);

        rr_mode = 2;
        place_job(2, 1, 1);
        respond(0, 0, 0);

        place_job(4, 1, 1);
        respond(5, 1, 1);
        chk("short_err", int'(err), 1);
        chk("short_results", obs_r, 5);
        chk("short_last", obs_last, 4);

        place_job(4, 1, 1);
        step();
        rst_n = 0;
        iss_t0 = -1000; exp_busy = 0; exp_err = 0; dr_on = 0; end_pending = 0;
        err_set_at = -1; busy_clr_at = -1; dr_t0 = -1;
        #1;
        chk("rst_mid_q_in_valid", int'(q_in_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_h_ready", int'(h_ready), 1);
        step();
        step();
        rst_n = 1;
        step();
        dcol[0] = 4'd9; drow[0] = 4'd1;
        dcol[1] = 4'd2; drow[1] = 4'd10;
        place_job(2, 1, 0);
        respond(12, 3, 0);
        chk("after_rst_num", obs_num0, 2);
        chk("after_rst_beats", obs_iss, 2);

        for (int j = 0; j < 30; j++) begin
            n = $urandom_range(1, 7);
            ul = n < 7 ? 1'b1 : 1'($urandom_range(0, 1));
            rr_mode = $urandom_range(0, 2);
            sel = $urandom_range(0, 19);
            m = sel == 0 ? 0 : sel < 5 ? $urandom_range(1, 11) : $urandom_range(12, 14);
            place_job(n, ul, 1);
            respond(m, $urandom_range(0, 6), 0);
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
